// File: rtl/ref_pkg.sv
// Shared types and default timing for the CBR refresh sequencer.
package ref_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CAS,
    RAS,
    PRE
  } ref_state_e;

  localparam int CAS_SETUP_DEF    = 1;
  localparam int RAS_CYC_DEF      = 3;
  localparam int PRE_CYC_DEF      = 2;
  localparam int ROWS_PER_REQ_DEF = 1;
  localparam int REF_ROWS_MAX     = 4;

  // A state lasting N cycles is entered with the phase timer loaded to N-1.
  function automatic logic [2:0] phase_load(input int cycles);
    return 3'(cycles - 1);
  endfunction

endpackage

// File: rtl/ref_phase_timer.sv
// Loadable 3-bit down-counter with a zero flag; reloaded on every state entry.
module ref_phase_timer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  output logic       zero_o
);

  logic [2:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= 3'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/ram_refresh_seq.sv
// CAS-before-RAS refresh sequencer: one burst of ROWS_PER_REQ rows per refresh window.
// Optional miss counter (RefMiss / RefMissPulse) is built when REF_MISS_CNT_EN is defined.
module ram_refresh_seq
  import ref_pkg::*;
#(
  parameter int CAS_SETUP    = CAS_SETUP_DEF,
  parameter int RAS_CYC      = RAS_CYC_DEF,
  parameter int PRE_CYC      = PRE_CYC_DEF,
  parameter int ROWS_PER_REQ = ROWS_PER_REQ_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RefReq,
  input  logic       RefUrg,
  input  logic       BACT,
  input  logic       RAMBusy,
  output logic       RefActive,
  output logic       RAMHold,
  output logic       nRASref,
  output logic       nCASref,
  output logic       RefDone
`ifdef REF_MISS_CNT_EN
  ,
  output logic [7:0] RefMiss,
  output logic       RefMissPulse
`endif
);

  localparam int ROW_W = $clog2(REF_ROWS_MAX);

  ref_state_e       state_q;
  logic [ROW_W-1:0] row_q;
  logic             ref_active_q;
  logic             ram_hold_q;
  logic             nras_q;
  logic             ncas_q;
  logic             ref_done_q;
  logic             void_q;

  logic             pend;
  logic             start_ok;
  logic             last_row;
  logic             leave_pre;
  logic             tmr_zero;
  logic             tmr_load;
  logic [2:0]       tmr_val;

  assign pend      = RefReq && !ref_done_q;
  assign start_ok  = pend && !RAMBusy && (!BACT || ram_hold_q);
  assign last_row  = (({1'b0, row_q} + (ROW_W+1)'(1)) == (ROW_W+1)'(ROWS_PER_REQ));
  assign leave_pre = (state_q == PRE) && tmr_zero && last_row;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 3'd0;
    case (state_q)
      START: begin
        tmr_load = 1'b1;
        tmr_val  = phase_load(CAS_SETUP);
      end
      CAS: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = phase_load(RAS_CYC);
      end
      RAS: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = phase_load(PRE_CYC);
      end
      PRE: if (tmr_zero && !last_row) begin
        tmr_load = 1'b1;
        tmr_val  = phase_load(CAS_SETUP);
      end
      default: ;
    endcase
  end

  ref_phase_timer u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      row_q        <= '0;
      ref_active_q <= 1'b0;
      ram_hold_q   <= 1'b0;
      nras_q       <= 1'b1;
      ncas_q       <= 1'b1;
      ref_done_q   <= 1'b0;
      void_q       <= 1'b0;
    end else begin
      ram_hold_q <= (pend && RefUrg) || (state_q != IDLE);

      // A window reset always wins over crediting a burst that ends on the same edge.
      if (!RefReq) begin
        ref_done_q <= 1'b0;
      end else if (leave_pre && !void_q) begin
        ref_done_q <= 1'b1;
      end

      case (state_q)
        IDLE: if (start_ok) begin
          state_q      <= START;
          ref_active_q <= 1'b1;
          void_q       <= 1'b0;
        end
        START: begin
          state_q <= CAS;
          ncas_q  <= 1'b0;
        end
        CAS: if (tmr_zero) begin
          state_q <= RAS;
          nras_q  <= 1'b0;
        end
        RAS: if (tmr_zero) begin
          state_q <= PRE;
          nras_q  <= 1'b1;
          ncas_q  <= 1'b1;
        end
        PRE: if (tmr_zero) begin
          if (last_row) begin
            state_q      <= IDLE;
            ref_active_q <= 1'b0;
            row_q        <= '0;
          end else begin
            state_q <= CAS;
            ncas_q  <= 1'b0;
            row_q   <= row_q + ROW_W'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          ref_active_q <= 1'b0;
          nras_q       <= 1'b1;
          ncas_q       <= 1'b1;
        end
      endcase

      // A window that closes while the burst runs leaves this burst uncredited.
      if (state_q != IDLE && !RefReq) begin
        void_q <= 1'b1;
      end
    end
  end

  assign RefActive = ref_active_q;
  assign RAMHold   = ram_hold_q;
  assign nRASref   = nras_q;
  assign nCASref   = ncas_q;
  assign RefDone   = ref_done_q;

`ifdef REF_MISS_CNT_EN
  logic       req_prev_q;
  logic [7:0] miss_cnt_q;
  logic       miss_pulse_q;
  logic       miss;

  assign miss = req_prev_q && !RefReq && !ref_done_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_prev_q   <= 1'b0;
      miss_cnt_q   <= 8'd0;
      miss_pulse_q <= 1'b0;
    end else begin
      req_prev_q   <= RefReq;
      miss_pulse_q <= miss;
      if (miss && (miss_cnt_q != 8'hFF)) begin
        miss_cnt_q <= miss_cnt_q + 8'd1;
      end
    end
  end

  assign RefMiss      = miss_cnt_q;
  assign RefMissPulse = miss_pulse_q;
`endif

endmodule

// File: tb/tb_ram_refresh_seq.sv
// Bench for ram_refresh_seq: two instances (1 and 2 rows per request) against a burst-position model.
module tb_ram_refresh_seq;

  localparam int CAS_C = 1;
  localparam int RAS_C = 3;
  localparam int PRE_C = 2;
  localparam int T_ROW = CAS_C + RAS_C + PRE_C;

  logic clk;
  logic rst, req, urg, bact, ramb;
  logic [1:0] act, hold, nras, ncas, done;
`ifdef REF_MISS_CNT_EN
  logic [7:0] miss [2];
  logic [1:0] mpulse;
`endif

  int vectors;
  int miscompares;
  bit chk_en;

  // Model state: burst position counted from the START cycle.
  bit m_busy [2];
  int m_p    [2];
  bit m_done [2];
  bit m_hold [2];
  bit m_void [2];
  bit m_reqp;
  int m_miss [2];
  bit m_mpulse [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ram_refresh_seq #(
      .CAS_SETUP    (CAS_C),
      .RAS_CYC      (RAS_C),
      .PRE_CYC      (PRE_C),
      .ROWS_PER_REQ (gi + 1)
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .RefReq    (req),
      .RefUrg    (urg),
      .BACT      (bact),
      .RAMBusy   (ramb),
      .RefActive (act[gi]),
      .RAMHold   (hold[gi]),
      .nRASref   (nras[gi]),
      .nCASref   (ncas[gi]),
      .RefDone   (done[gi])
`ifdef REF_MISS_CNT_EN
      ,
      .RefMiss      (miss[gi]),
      .RefMissPulse (mpulse[gi])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int burst_len(input int k);
    return 1 + (k + 1) * T_ROW;
  endfunction

  function automatic bit pend_of(input int k);
    return req && !m_done[k];
  endfunction

  function automatic bit exp_ncas(input int k);
    int q;
    if (!m_busy[k] || m_p[k] == 0) return 1'b1;
    q = (m_p[k] - 1) % T_ROW;
    return !(q < CAS_C + RAS_C);
  endfunction

  function automatic bit exp_nras(input int k);
    int q;
    if (!m_busy[k] || m_p[k] == 0) return 1'b1;
    q = (m_p[k] - 1) % T_ROW;
    return !(q >= CAS_C && q < CAS_C + RAS_C);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k]   <= 1'b0;
        m_p[k]      <= 0;
        m_done[k]   <= 1'b0;
        m_hold[k]   <= 1'b0;
        m_void[k]   <= 1'b0;
        m_miss[k]   <= 0;
        m_mpulse[k] <= 1'b0;
      end else begin
        m_hold[k] <= (pend_of(k) && urg) || m_busy[k];
        if (!req)
          m_done[k] <= 1'b0;
        else if (m_busy[k] && m_p[k] == burst_len(k) - 1 && !m_void[k])
          m_done[k] <= 1'b1;
        if (m_busy[k]) begin
          if (!req) m_void[k] <= 1'b1;
          if (m_p[k] == burst_len(k) - 1) begin
            m_busy[k] <= 1'b0;
            m_p[k]    <= 0;
          end else begin
            m_p[k] <= m_p[k] + 1;
          end
        end else if (pend_of(k) && !ramb && (!bact || m_hold[k])) begin
          m_busy[k] <= 1'b1;
          m_p[k]    <= 0;
          m_void[k] <= 1'b0;
        end
        if (m_reqp && !req && !m_done[k]) begin
          m_mpulse[k] <= 1'b1;
          if (m_miss[k] < 255) m_miss[k] <= m_miss[k] + 1;
        end else begin
          m_mpulse[k] <= 1'b0;
        end
      end
    end
    m_reqp <= rst ? 1'b0 : req;
  end

  task automatic check(input string nm, input int k, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0d expected %0d at t=%0t", nm, k, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("RefActive", k, act[k], m_busy[k]);
        check("RAMHold", k, hold[k], m_hold[k]);
        check("nRASref", k, nras[k], exp_nras(k));
        check("nCASref", k, ncas[k], exp_ncas(k));
        check("RefDone", k, done[k], m_done[k]);
`ifdef REF_MISS_CNT_EN
        check("RefMiss", k, miss[k], m_miss[k]);
        check("RefMissPulse", k, mpulse[k], m_mpulse[k]);
`endif
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [8:0] e_act, e_ncas, e_nras, e_done, e_hold;
    int rises;
    bit prev;
    int pulses;

    vectors = 0;
    miscompares = 0;
    chk_en = 1'b0;
    rst = 1'b1; req = 1'b0; urg = 1'b0; bact = 1'b0; ramb = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_act", 0, act[0], 0);
    check("reset_nras", 0, nras[0], 1);
    check("reset_done", 1, done[1], 0);

    // Default single-row burst, then the two-row instance to completion.
    e_act  = 9'b111111100;
    e_ncas = 9'b100001111;
    e_nras = 9'b110001111;
    e_done = 9'b000000011;
    e_hold = 9'b011111110;
    rst = 1'b0; req = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n <= 9) begin
        check("lit_act", 0, act[0], e_act[9-n]);
        check("lit_ncas", 0, ncas[0], e_ncas[9-n]);
        check("lit_nras", 0, nras[0], e_nras[9-n]);
        check("lit_done", 0, done[0], e_done[9-n]);
        check("lit_hold", 0, hold[0], e_hold[9-n]);
      end
      if (n == 8) begin
        check("lit2_ncas_row2", 1, ncas[1], 0);
        check("lit2_nras_row2", 1, nras[1], 1);
      end
      if (n == 9)  check("lit2_nras_row2b", 1, nras[1], 0);
      if (n == 13) begin
        check("lit2_act13", 1, act[1], 1);
        check("lit2_done13", 1, done[1], 0);
      end
      if (n == 14) begin
        check("lit2_act14", 1, act[1], 0);
        check("lit2_done14", 1, done[1], 1);
      end
    end

    // One-cycle window reset: RefDone clears, then exactly one new burst.
    req = 1'b0;
    @(negedge clk);
    check("win_clear", 0, done[0], 0);
    req = 1'b1;
    @(negedge clk);
    check("win_restart", 0, act[0], 1);
    rises = 0;
    prev = act[0];
    repeat (20) begin
      @(negedge clk);
      if (act[0] && !prev) rises++;
      prev = act[0];
    end
    check("win_extra_bursts", 0, rises, 0);
    check("win_done", 0, done[0], 1);

    // BACT blocks refresh until urgent; RAMBusy still holds it off.
    do_reset();
    req = 1'b1; bact = 1'b1; urg = 1'b0;
    repeat (8) @(negedge clk);
    check("bact_block_act", 0, act[0], 0);
    check("bact_block_hold", 0, hold[0], 0);
    urg = 1'b1; ramb = 1'b1;
    @(negedge clk);
    check("urg_hold", 0, hold[0], 1);
    check("urg_busy_act", 0, act[0], 0);
    repeat (2) @(negedge clk);
    check("urg_busy_act2", 0, act[0], 0);
    ramb = 1'b0;
    @(negedge clk);
    check("urg_start", 0, act[0], 1);

    // Reset during RAS.
    repeat (2) @(negedge clk);
    check("ras_reached", 0, nras[0], 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_nras", 0, nras[0], 1);
    check("rst_ncas", 0, ncas[0], 1);
    check("rst_act", 0, act[0], 0);
    check("rst_hold", 0, hold[0], 0);
    rst = 1'b0; urg = 1'b0;

`ifdef REF_MISS_CNT_EN
    // 300 missed periods saturate the counter.
    do_reset();
    bact = 1'b1; urg = 1'b0; ramb = 1'b0;
    pulses = 0;
    for (int p = 0; p < 300; p++) begin
      req = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (mpulse[0]) pulses++;
      end
      req = 1'b0;
      @(negedge clk);
      if (mpulse[0]) pulses++;
    end
    check("miss_sat", 0, miss[0], 255);
    check("miss_pulses", 0, pulses, 300);
`else
    pulses = 0;
`endif

    // Randomized traffic including occasional resets and urgency without a window.
    req = 1'b1; bact = 1'b0; urg = 1'b0; ramb = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if (req) req = ($urandom_range(0, 39) != 0);
      else     req = ($urandom_range(0, 1) == 0);
      urg  = ($urandom_range(0, 3) == 0);
      bact = ($urandom_range(0, 1) == 0);
      ramb = ($urandom_range(0, 3) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
